// File: rtl/hbmc_rx_pkg.sv
// Shared constants and edge-type encoding for HyperBus read-data recovery.
package hbmc_rx_pkg;

    localparam int unsigned SAMPLES_PER_CYCLE = 6;
    localparam int unsigned DQ_WIDTH          = 8;
    localparam int unsigned WINDOW_LEN        = 12;
    localparam int unsigned WORD_WIDTH        = 16;
    localparam int unsigned WORD_SLOTS        = 2;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_t;

endpackage

// File: rtl/hbmc_rwds_edge_detect.sv
// Classifies each of the 6 window positions as rise/fall/none.
// Bit 0 of rwds is the reference sample carried over from the previous window.
module hbmc_rwds_edge_detect
    import hbmc_rx_pkg::*;
(
    input  logic [SAMPLES_PER_CYCLE:0] rwds,
    output edge_t                      edges [SAMPLES_PER_CYCLE]
);

    always_comb begin
        for (int k = 0; k < int'(SAMPLES_PER_CYCLE); k++) begin
            edges[k] = EDGE_NONE;
            if (rwds[k+1] && !rwds[k]) begin
                edges[k] = EDGE_RISE;
            end else if (!rwds[k+1] && rwds[k]) begin
                edges[k] = EDGE_FALL;
            end
        end
    end

endmodule

// File: rtl/hbmc_rwds_data_recovery.sv
// Recovers 16-bit HyperBus read words from oversampled RWDS/DQ streams.
// Define HBMC_RX_STATS_EN to add saturating word/error counters.
module hbmc_rwds_data_recovery
    import hbmc_rx_pkg::*;
#(
    parameter int unsigned SAMPLE_OFFSET      = 2,
    parameter bit          ERR_ON_DOUBLE_RISE = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rx_en,
    input  logic [SAMPLES_PER_CYCLE-1:0]        rwds_samples,
    input  logic [SAMPLES_PER_CYCLE*DQ_WIDTH-1:0] dq_samples,
    output logic [WORD_SLOTS*WORD_WIDTH-1:0]    word_o,
    output logic [WORD_SLOTS-1:0]               word_vld_o,
    output logic                                err_o
`ifdef HBMC_RX_STATS_EN
    ,
    output logic [31:0]                         stat_words_o,
    output logic [15:0]                         stat_errs_o
`endif
);

    localparam int unsigned DQ_BITS = SAMPLES_PER_CYCLE * DQ_WIDTH;

    logic [SAMPLES_PER_CYCLE-1:0] a_rwds, b_rwds;
    logic [DQ_BITS-1:0]           a_dq, b_dq;
    logic                         a_en, b_en;
    logic                         prev_rwds;
    logic                         pending;
    logic [DQ_WIDTH-1:0]          high_byte;

    edge_t                        edges [SAMPLES_PER_CYCLE];
    logic [WINDOW_LEN-1:0]        dq_lane  [DQ_WIDTH];
    logic [DQ_WIDTH-1:0]          win_byte [WINDOW_LEN];

    logic                         pend_nxt;
    logic [DQ_WIDTH-1:0]          high_nxt;
    logic [DQ_WIDTH-1:0]          cap;
    logic [WORD_SLOTS*WORD_WIDTH-1:0] word_nxt;
    logic [WORD_SLOTS-1:0]        vld_nxt;
    logic                         err_nxt;

    hbmc_rwds_edge_detect u_edge_detect (
        .rwds  ({b_rwds, prev_rwds}),
        .edges (edges)
    );

    // Per-lane 12-sample history (B then A), regrouped into one byte per window position.
    always_comb begin
        for (int i = 0; i < int'(DQ_WIDTH); i++) begin
            dq_lane[i] = {a_dq[SAMPLES_PER_CYCLE*i +: SAMPLES_PER_CYCLE],
                          b_dq[SAMPLES_PER_CYCLE*i +: SAMPLES_PER_CYCLE]};
        end
        for (int p = 0; p < int'(WINDOW_LEN); p++) begin
            for (int i = 0; i < int'(DQ_WIDTH); i++) begin
                win_byte[p][i] = dq_lane[i][p];
            end
        end
    end

    // Walk edges in position order, pairing rise/fall bytes into words.
    always_comb begin
        pend_nxt = pending;
        high_nxt = high_byte;
        cap      = '0;
        word_nxt = '0;
        vld_nxt  = '0;
        err_nxt  = 1'b0;
        if (!b_en) begin
            pend_nxt = 1'b0;
        end else begin
            for (int k = 0; k < int'(SAMPLES_PER_CYCLE); k++) begin
                cap = win_byte[k + int'(SAMPLE_OFFSET)];
                unique case (edges[k])
                    EDGE_RISE: begin
                        if (pend_nxt && ERR_ON_DOUBLE_RISE) begin
                            err_nxt = 1'b1;
                        end
                        high_nxt = cap;
                        pend_nxt = 1'b1;
                    end
                    EDGE_FALL: begin
                        if (pend_nxt) begin
                            if (!vld_nxt[0]) begin
                                word_nxt[WORD_WIDTH-1:0] = {high_nxt, cap};
                                vld_nxt[0]               = 1'b1;
                            end else if (!vld_nxt[1]) begin
                                word_nxt[2*WORD_WIDTH-1:WORD_WIDTH] = {high_nxt, cap};
                                vld_nxt[1]                          = 1'b1;
                            end
                            pend_nxt = 1'b0;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rwds     <= '0;
            a_dq       <= '0;
            a_en       <= 1'b0;
            b_rwds     <= '0;
            b_dq       <= '0;
            b_en       <= 1'b0;
            prev_rwds  <= 1'b0;
            pending    <= 1'b0;
            high_byte  <= '0;
            word_o     <= '0;
            word_vld_o <= '0;
            err_o      <= 1'b0;
        end else begin
            a_rwds     <= rwds_samples;
            a_dq       <= dq_samples;
            a_en       <= rx_en;
            b_rwds     <= a_rwds;
            b_dq       <= a_dq;
            b_en       <= a_en;
            prev_rwds  <= b_rwds[SAMPLES_PER_CYCLE-1];
            pending    <= pend_nxt;
            high_byte  <= high_nxt;
            word_o     <= word_nxt;
            word_vld_o <= vld_nxt;
            err_o      <= err_nxt;
        end
    end

`ifdef HBMC_RX_STATS_EN
    logic [32:0] words_sum;

    assign words_sum = {1'b0, stat_words_o} + 33'(word_vld_o[0]) + 33'(word_vld_o[1]);

    // Saturating counters over the registered output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words_o <= '0;
            stat_errs_o  <= '0;
        end else begin
            stat_words_o <= words_sum[32] ? '1 : words_sum[31:0];
            if (err_o && (stat_errs_o != '1)) begin
                stat_errs_o <= stat_errs_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hbmc_rwds_data_recovery.sv
// Scoreboard bench for hbmc_rwds_data_recovery: directed bursts plus a legal random RWDS walk.
module tb_hbmc_rwds_data_recovery;
    import hbmc_rx_pkg::*;

    localparam int unsigned OFF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_en;
    logic [5:0]  rwds_samples;
    logic [47:0] dq_samples;
    logic [31:0] word_o;
    logic [1:0]  word_vld_o;
    logic        err_o;
`ifdef HBMC_RX_STATS_EN
    logic [31:0] stat_words_o;
    logic [15:0] stat_errs_o;
`endif

    always #5 clk = ~clk;

    hbmc_rwds_data_recovery #(
        .SAMPLE_OFFSET      (OFF),
        .ERR_ON_DOUBLE_RISE (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_en        (rx_en),
        .rwds_samples (rwds_samples),
        .dq_samples   (dq_samples),
        .word_o       (word_o),
        .word_vld_o   (word_vld_o),
`ifdef HBMC_RX_STATS_EN
        .stat_words_o (stat_words_o),
        .stat_errs_o  (stat_errs_o),
`endif
        .err_o        (err_o)
    );

    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  vld;
        logic        err;
    } exp_t;

    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state and the previous cycle's stimulus (the B stage).
    logic        m_prev, m_pend;
    logic [7:0]  m_high;
    logic [5:0]  h_rwds;
    logic [7:0]  h_bytes [6];
    logic        h_en;
    logic [7:0]  bb [6];

    // Random legal RWDS walk: runs of 2..4 samples between transitions.
    logic        lvl = 1'b0;
    int          run_left = 3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic rand_bytes();
        for (int s = 0; s < 6; s++) bb[s] = 8'($urandom);
    endtask

    task automatic model_step(input logic [7:0] a_bytes [6], output exp_t e);
        logic [7:0] win [12];
        logic       last;
        e = '0;
        for (int p = 0; p < 6; p++) begin
            win[p]   = h_bytes[p];
            win[p+6] = a_bytes[p];
        end
        if (!h_en) begin
            m_pend = 1'b0;
        end else begin
            last = m_prev;
            for (int k = 0; k < 6; k++) begin
                if (h_rwds[k] != last) begin
                    if (h_rwds[k]) begin
                        if (m_pend) e.err = 1'b1;
                        m_high = win[k+OFF];
                        m_pend = 1'b1;
                    end else if (m_pend) begin
                        if (!e.vld[0]) begin
                            e.word[15:0] = {m_high, win[k+OFF]};
                            e.vld[0] = 1'b1;
                        end else if (!e.vld[1]) begin
                            e.word[31:16] = {m_high, win[k+OFF]};
                            e.vld[1] = 1'b1;
                        end
                        m_pend = 1'b0;
                    end else begin
                        e.err = 1'b1;
                    end
                end
                last = h_rwds[k];
            end
        end
        m_prev = h_rwds[5];
    endtask

    // One clock of stimulus; compares the output registered at this edge.
    task automatic drive(input logic [5:0] r, input logic [7:0] bytes [6],
                         input logic en, input logic rs);
        exp_t e;
        rwds_samples = r;
        rx_en        = en;
        rst          = rs;
        for (int s = 0; s < 6; s++)
            for (int i = 0; i < 8; i++)
                dq_samples[6*i+s] = bytes[s][i];
        @(posedge clk);
        #1;
        if (rs) begin
            exp_q.delete();
            check("rst_word", word_o, 32'd0);
            check("rst_vld", 32'(word_vld_o), 32'd0);
            check("rst_err", 32'(err_o), 32'd0);
`ifdef HBMC_RX_STATS_EN
            check("rst_stat_words", stat_words_o, 32'd0);
            check("rst_stat_errs", 32'(stat_errs_o), 32'd0);
`endif
            m_prev = 1'b0;
            m_pend = 1'b0;
            m_high = 8'd0;
            h_rwds = 6'd0;
            h_en   = 1'b0;
            for (int s = 0; s < 6; s++) h_bytes[s] = 8'd0;
            exp_q.push_back('0);
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_word", word_o, e.word);
                check("sb_vld", 32'(word_vld_o), 32'(e.vld));
                check("sb_err", 32'(err_o), 32'(e.err));
            end
            model_step(bytes, e);
            exp_q.push_back(e);
            h_rwds  = r;
            h_bytes = bytes;
            h_en    = en;
        end
    endtask

    function automatic logic [5:0] walk_rwds();
        logic [5:0] r;
        for (int s = 0; s < 6; s++) begin
            r[s] = lvl;
            run_left--;
            if (run_left == 0) begin
                lvl      = ~lvl;
                run_left = int'($urandom_range(4, 2));
            end
        end
        return r;
    endfunction

    initial begin
        rst = 1'b1; rx_en = 1'b0; rwds_samples = '0; dq_samples = '0;
        m_prev = 1'b0; m_pend = 1'b0; m_high = '0;
        h_rwds = '0; h_en = 1'b0;
        for (int s = 0; s < 6; s++) begin h_bytes[s] = '0; bb[s] = '0; end

        drive(6'b0, bb, 1'b0, 1'b1);
        drive(6'b0, bb, 1'b0, 1'b1);

        // Nominal: rise at 3 (byte at 5), fall at 0 (byte at 2)
        for (int c = 0; c < 6; c++) begin
            rand_bytes(); bb[2] = 8'h3C; bb[5] = 8'hA5;
            drive(6'b111000, bb, 1'b1, 1'b0);
        end
        check("nom_word", word_o, 32'h0000_A53C);
        check("nom_vld", 32'(word_vld_o), 32'd1);

        // Jittered F,R,F with a pending high byte; last byte comes from lookahead
        rand_bytes(); bb[2] = 8'h11; bb[3] = 8'h22;
        drive(6'b001110, bb, 1'b1, 1'b0);
        rand_bytes(); bb[0] = 8'h33; bb[2] = 8'h3C; bb[5] = 8'hA5;
        drive(6'b111000, bb, 1'b1, 1'b0);
        rand_bytes(); bb[2] = 8'h3C; bb[5] = 8'hA5;
        drive(6'b111000, bb, 1'b1, 1'b0);
        check("jit_word", word_o, 32'h2233_A511);
        check("jit_vld", 32'(word_vld_o), 32'd3);
        check("jit_err", 32'(err_o), 32'd0);

        // Orphan fall: disabled all-ones window primes the reference sample
        for (int s = 0; s < 6; s++) bb[s] = '0;
        drive(6'b0, bb, 1'b0, 1'b1);
        drive(6'b111111, bb, 1'b0, 1'b0);
        drive(6'b000111, bb, 1'b1, 1'b0);
        drive(6'b000000, bb, 1'b1, 1'b0);
        drive(6'b000000, bb, 1'b1, 1'b0);
        check("orph_err", 32'(err_o), 32'd1);
        check("orph_vld", 32'(word_vld_o), 32'd0);

        // Rise, disabled window, rise again: word carries the second high byte
        rand_bytes(); bb[5] = 8'h5A; drive(6'b111000, bb, 1'b1, 1'b0);
        rand_bytes();                drive(6'b000000, bb, 1'b0, 1'b0);
        rand_bytes(); bb[5] = 8'h77; drive(6'b111000, bb, 1'b1, 1'b0);
        rand_bytes(); bb[2] = 8'h99; drive(6'b000000, bb, 1'b1, 1'b0);
        rand_bytes();                drive(6'b000000, bb, 1'b1, 1'b0);
        rand_bytes();                drive(6'b000000, bb, 1'b1, 1'b0);
        check("dr_word", word_o, 32'h0000_7799);
        check("dr_vld", 32'(word_vld_o), 32'd1);

        // rx_en low for 4 cycles while RWDS keeps toggling
        for (int c = 0; c < 3; c++) begin
            rand_bytes(); bb[2] = 8'h3C; bb[5] = 8'hA5;
            drive(6'b111000, bb, 1'b1, 1'b0);
        end
        for (int c = 0; c < 4; c++) begin
            rand_bytes(); bb[2] = 8'h3C; bb[5] = 8'hA5;
            drive(6'b111000, bb, 1'b0, 1'b0);
        end
        check("dis_vld", 32'(word_vld_o), 32'd0);
        for (int c = 0; c < 4; c++) begin
            rand_bytes(); bb[2] = 8'h3C; bb[5] = 8'hA5;
            drive(6'b111000, bb, 1'b1, 1'b0);
        end
        check("reen_word", word_o, 32'h0000_A53C);
        check("reen_vld", 32'(word_vld_o), 32'd1);

        // Random legal bursts with occasional disable and one mid-burst reset
        for (int c = 0; c < 80; c++) begin
            rand_bytes();
            drive(walk_rwds(), bb, ($urandom_range(9, 0) != 0), (c == 40));
        end

        for (int s = 0; s < 6; s++) bb[s] = '0;
        for (int c = 0; c < 3; c++) drive(6'b0, bb, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
